// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants for the UART transmit path: default widths and the
// one-hot encoding of the launch FSM.
package uart_tx_fifo_pkg;

  localparam int UART_NB_DATA = 8;
  localparam int UART_NB_ADDR = 4;

  localparam int NB_STATE = 3;

  localparam logic [NB_STATE-1:0] ST_IDLE      = 3'b001;
  localparam logic [NB_STATE-1:0] ST_LAUNCH    = 3'b010;
  localparam logic [NB_STATE-1:0] ST_WAIT_DONE = 3'b100;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and a sticky overflow flag.
// Writes that arrive while full are dropped.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int NB_DATA = UART_NB_DATA,
  parameter int NB_ADDR = UART_NB_ADDR
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  input  logic               i_clear_overflow,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_overflow
);

  localparam int DEPTH = 2 ** NB_ADDR;

  localparam logic [NB_ADDR:0]   CNT_FULL = {1'b1, {NB_ADDR{1'b0}}};
  localparam logic [NB_ADDR:0]   CNT_ONE  = {{NB_ADDR{1'b0}}, 1'b1};
  localparam logic [NB_ADDR-1:0] PTR_ONE  = {{(NB_ADDR-1){1'b0}}, 1'b1};

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_ptr;
  logic [NB_ADDR:0]   count;
  logic               do_wr;
  logic               do_rd;

  // Full/empty come from the registered count, so a pop in the same cycle
  // never makes room for a write that arrives while full.
  assign o_full  = (count == CNT_FULL);
  assign o_empty = (count == '0);
  assign o_count = count;

  assign do_wr = i_wr_en && !o_full;
  assign do_rd = i_rd_en && !o_empty;

  assign o_rd_data = mem[rd_ptr];

  // NOTE: storage has no reset; stale entries are unreachable once the
  // pointers and count are cleared, and a resettable RAM costs a flop array.
  always_ff @(posedge i_clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally at 2**NB_ADDR.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_overflow <= 1'b0;
    end else if (i_wr_en && o_full) begin
      o_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      o_overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer for the UART: queues bytes and launches them one at a
// time, waiting for the transmitter's done pulse between bytes.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int NB_DATA = UART_NB_DATA,
  parameter int NB_ADDR = UART_NB_ADDR
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic               i_wr_en,
  input  logic               i_clear_overflow,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_full,
  output logic               o_empty,
  output logic [NB_ADDR:0]   o_count,
  output logic               o_busy,
  output logic               o_overflow
);

  logic [NB_STATE-1:0] state;
  logic [NB_STATE-1:0] state_next;
  logic                pop;
  logic                start_next;
  logic [NB_DATA-1:0]  head_data;
  logic                fifo_empty;

  sync_fifo #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_fifo (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_wr_data        (i_wr_data),
    .i_wr_en          (i_wr_en),
    .i_rd_en          (pop),
    .i_clear_overflow (i_clear_overflow),
    .o_rd_data        (head_data),
    .o_full           (o_full),
    .o_empty          (fifo_empty),
    .o_count          (o_count),
    .o_overflow       (o_overflow)
  );

  assign o_empty = fifo_empty;
  assign o_busy  = (state != ST_IDLE);

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    start_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          start_next = 1'b1;
          state_next = ST_LAUNCH;
        end
      end
      // Done is deliberately ignored here: the transmitter cannot have
      // finished a byte it has not yet been told to start.
      ST_LAUNCH: begin
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      state      <= state_next;
      o_tx_start <= start_next;
      if (pop) begin
        o_tx_data <= head_data;
      end
    end
  end

endmodule
